// File: rtl/gm64_pkg.sv
// rtl/gm64_pkg.sv - shared gm64 types and widths for the PSRAM arbiter
package gm64_pkg;

  localparam int PSRAM_ADDR_W = 24;
  localparam int PSRAM_DATA_W = 8;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT_BUSY,
    ARB_WAIT_DONE,
    ARB_ACK
  } arb_state_e;

  typedef enum bit [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_VIC  = 2'd1,
    OWNER_CPU  = 2'd2,
    OWNER_AUX  = 2'd3
  } owner_e;

  // Debug border colour per bus owner, driven from o_owner
  typedef enum logic [1:0] {
    COLOR_BLACK = 2'd0,
    COLOR_BLUE  = 2'd1,
    COLOR_GREEN = 2'd2,
    COLOR_RED   = 2'd3
  } color_e;

endpackage

// File: rtl/psram_prio_select.sv
// rtl/psram_prio_select.sv - fixed-priority winner pick with AUX starvation override
module psram_prio_select
  import gm64_pkg::*;
(
  input  logic   vic_req,
  input  logic   cpu_req,
  input  logic   aux_req,
  input  logic   aux_force,
  output owner_e winner
);

  // VIC > CPU > AUX, unless AUX has been passed over too many times
  always_comb begin
    winner = OWNER_NONE;
    if (aux_req && aux_force) begin
      winner = OWNER_AUX;
    end else if (vic_req) begin
      winner = OWNER_VIC;
    end else if (cpu_req) begin
      winner = OWNER_CPU;
    end else if (aux_req) begin
      winner = OWNER_AUX;
    end
  end

endmodule

// File: rtl/psram_arbiter.sv
// rtl/psram_arbiter.sv - shares memCtrl between VIC, CPU and AUX requesters
module psram_arbiter
  import gm64_pkg::*;
#(
  parameter int ADDR_W       = PSRAM_ADDR_W,
  parameter int DATA_W       = PSRAM_DATA_W,
  parameter int TIMEOUT      = 1023,
  parameter int STARVE_LIMIT = 15
) (
  input  logic              clkSys,
  input  logic              reset,
  input  logic              i_vic_req,
  input  logic              i_cpu_req,
  input  logic              i_aux_req,
  input  logic              i_vic_write,
  input  logic              i_cpu_write,
  input  logic              i_aux_write,
  input  logic [ADDR_W-1:0] i_vic_addr,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [ADDR_W-1:0] i_aux_addr,
  input  logic [DATA_W-1:0] i_vic_wdata,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  input  logic [DATA_W-1:0] i_aux_wdata,
  output logic              o_vic_ack,
  output logic              o_cpu_ack,
  output logic              o_aux_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_err,
  output logic              o_mem_cs_n,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_busy,
  input  logic              i_mem_ready,
  output logic [1:0]        o_owner
);

  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e          state;
  owner_e              owner_q;
  owner_e              winner;
  logic [TCNT_W-1:0]   tcnt;
  logic [SCNT_W-1:0]   starve;
  logic                aux_force;
  logic                tcnt_max;
  logic                done_ok;
  logic                timed_out;
  logic                sel_write;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  assign aux_force = (starve == SCNT_W'(STARVE_LIMIT));
  assign tcnt_max  = (tcnt == TCNT_W'(TIMEOUT));
  assign o_owner   = owner_q;

  psram_prio_select u_prio (
    .vic_req   (i_vic_req),
    .cpu_req   (i_cpu_req),
    .aux_req   (i_aux_req),
    .aux_force (aux_force),
    .winner    (winner)
  );

  // Route the winning requester's command fields toward memCtrl
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    case (winner)
      OWNER_VIC: begin
        sel_write = i_vic_write;
        sel_addr  = i_vic_addr;
        sel_wdata = i_vic_wdata;
      end
      OWNER_CPU: begin
        sel_write = i_cpu_write;
        sel_addr  = i_cpu_addr;
        sel_wdata = i_cpu_wdata;
      end
      OWNER_AUX: begin
        sel_write = i_aux_write;
        sel_addr  = i_aux_addr;
        sel_wdata = i_aux_wdata;
      end
      default: begin
        sel_write = 1'b0;
      end
    endcase
  end

  // Completion: writes end on busy fall, reads also need ready in that cycle;
  // a phase that overruns TIMEOUT is abandoned but still acked
  always_comb begin
    done_ok   = (state == ARB_WAIT_DONE) && !i_mem_busy && (o_mem_write || i_mem_ready);
    timed_out = ((state == ARB_WAIT_BUSY) || (state == ARB_WAIT_DONE)) && tcnt_max && !done_ok;
  end

  // Transaction sequencer with registered memCtrl/requester outputs
  always_ff @(posedge clkSys) begin
    if (reset) begin
      state       <= ARB_IDLE;
      owner_q     <= OWNER_NONE;
      tcnt        <= '0;
      starve      <= '0;
      o_mem_cs_n  <= 1'b1;
      o_mem_write <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_vic_ack   <= 1'b0;
      o_cpu_ack   <= 1'b0;
      o_aux_ack   <= 1'b0;
      o_rdata     <= '0;
      o_err       <= 1'b0;
    end else begin
      o_vic_ack <= 1'b0;
      o_cpu_ack <= 1'b0;
      o_aux_ack <= 1'b0;
      if (!i_aux_req) begin
        starve <= '0;
      end
      case (state)
        ARB_IDLE: begin
          if (!i_mem_busy && (winner != OWNER_NONE)) begin
            owner_q     <= winner;
            o_mem_cs_n  <= 1'b0;
            o_mem_write <= sel_write;
            o_mem_addr  <= sel_addr;
            o_mem_wdata <= sel_wdata;
            state       <= ARB_ISSUE;
            if (winner == OWNER_AUX) begin
              starve <= '0;
            end else if (i_aux_req && !aux_force) begin
              starve <= starve + 1'b1;
            end
          end
        end
        ARB_ISSUE: begin
          o_mem_cs_n <= 1'b1;
          tcnt       <= '0;
          state      <= ARB_WAIT_BUSY;
        end
        ARB_WAIT_BUSY: begin
          if (!tcnt_max) begin
            tcnt <= tcnt + 1'b1;
          end
          if (!timed_out && i_mem_busy) begin
            state <= ARB_WAIT_DONE;
          end
        end
        ARB_WAIT_DONE: begin
          if (!tcnt_max) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ARB_ACK: begin
          owner_q <= OWNER_NONE;
          state   <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
      if (done_ok || timed_out) begin
        state     <= ARB_ACK;
        o_vic_ack <= (owner_q == OWNER_VIC);
        o_cpu_ack <= (owner_q == OWNER_CPU);
        o_aux_ack <= (owner_q == OWNER_AUX);
        if (timed_out) begin
          o_err <= 1'b1;
          if (!o_mem_write) begin
            o_rdata <= '1;
          end
        end else if (!o_mem_write) begin
          o_rdata <= i_mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_psram_arbiter.sv
// tb/tb_psram_arbiter.sv - self-checking bench for psram_arbiter
module tb_psram_arbiter;

  localparam int TIMEOUT = 1023;

  typedef struct {
    int          who;
    bit          wr;
    logic [23:0] addr;
    logic [7:0]  wdata;
    int          blen;
    logic [7:0]  exp_rdata;
  } vec_t;

  logic        clkSys = 1'b0;
  logic        reset  = 1'b1;
  logic        rq_req  [3];
  logic        rq_wr   [3];
  logic [23:0] rq_addr [3];
  logic [7:0]  rq_wd   [3];
  logic        o_vic_ack, o_cpu_ack, o_aux_ack;
  logic [7:0]  o_rdata;
  logic        o_err, o_mem_cs_n, o_mem_write;
  logic [23:0] o_mem_addr;
  logic [7:0]  o_mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_busy, mem_ready;
  logic [1:0]  o_owner;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int cs_lows = 0;
  int ack_cycle = 0;
  bit keep_vc = 0;
  bit acked [3];
  int ack_order [$];
  int ack_owner [$];
  int ack_rdata [$];

  bit          mem_dead = 0;
  bit          rand_len = 0;
  int          busy_len = 4;
  int          m_cnt = 0;
  bit          m_write;
  logic [23:0] m_addr;
  logic [7:0]  m_wdata;
  logic [7:0]  model_mem [logic [23:0]];
  logic [7:0]  ref_mem   [logic [23:0]];

  psram_arbiter dut (
    .clkSys      (clkSys),
    .reset       (reset),
    .i_vic_req   (rq_req[0]),
    .i_cpu_req   (rq_req[1]),
    .i_aux_req   (rq_req[2]),
    .i_vic_write (rq_wr[0]),
    .i_cpu_write (rq_wr[1]),
    .i_aux_write (rq_wr[2]),
    .i_vic_addr  (rq_addr[0]),
    .i_cpu_addr  (rq_addr[1]),
    .i_aux_addr  (rq_addr[2]),
    .i_vic_wdata (rq_wd[0]),
    .i_cpu_wdata (rq_wd[1]),
    .i_aux_wdata (rq_wd[2]),
    .o_vic_ack   (o_vic_ack),
    .o_cpu_ack   (o_cpu_ack),
    .o_aux_ack   (o_aux_ack),
    .o_rdata     (o_rdata),
    .o_err       (o_err),
    .o_mem_cs_n  (o_mem_cs_n),
    .o_mem_write (o_mem_write),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (mem_rdata),
    .i_mem_busy  (mem_busy),
    .i_mem_ready (mem_ready),
    .o_owner     (o_owner)
  );

  initial forever #5 clkSys = ~clkSys;

  function automatic logic [7:0] dflt(logic [23:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // memCtrl stand-in: busy for busy_len cycles after cs, ready with data at busy fall
  initial begin
    mem_busy = 0; mem_ready = 0; mem_rdata = 0;
    forever begin
      @(posedge clkSys); #1;
      mem_ready = 0;
      if (reset) begin
        m_cnt = 0;
        mem_busy = 0;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          mem_busy = 0;
          if (m_write) model_mem[m_addr] = m_wdata;
          else begin
            mem_ready = 1;
            mem_rdata = model_mem.exists(m_addr) ? model_mem[m_addr] : dflt(m_addr);
          end
        end
      end else if (!o_mem_cs_n && !mem_dead) begin
        m_write = o_mem_write; m_addr = o_mem_addr; m_wdata = o_mem_wdata;
        mem_busy = 1;
        m_cnt = rand_len ? $urandom_range(2, 5) : busy_len;
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sample();
    int n;
    int k;
    if (!o_mem_cs_n) cs_lows++;
    n = int'(o_vic_ack) + int'(o_cpu_ack) + int'(o_aux_ack);
    if (n != 0) begin
      check("ack_onehot", n, 1);
      k = o_vic_ack ? 0 : (o_cpu_ack ? 1 : 2);
      ack_order.push_back(k);
      ack_owner.push_back(int'(o_owner));
      ack_rdata.push_back(int'(o_rdata));
      acked[k] = 1;
      ack_cycle = cyc;
      if (!(keep_vc && k < 2)) rq_req[k] = 0;
    end
  endtask

  task automatic step();
    @(negedge clkSys);
    cyc++;
    sample();
  endtask

  task automatic clear_log();
    ack_order.delete(); ack_owner.delete(); ack_rdata.delete();
    for (int k = 0; k < 3; k++) acked[k] = 0;
    cs_lows = 0;
  endtask

  task automatic do_txn(input int who, input bit wr, input logic [23:0] a, input logic [7:0] d,
                        input int blen, input int bound, output bit got, output int lat, output int alat);
    int start;
    busy_len = blen;
    clear_log();
    rq_wr[who] = wr; rq_addr[who] = a; rq_wd[who] = d; rq_req[who] = 1;
    start = cyc; lat = -1;
    for (int i = 0; i < bound && !acked[who]; i++) begin
      step();
      if (lat < 0 && !o_mem_cs_n) lat = cyc - start;
    end
    got = acked[who];
    alat = got ? ack_cycle - start : -1;
    if (!got) rq_req[who] = 0;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_cs_n"}, o_mem_cs_n, 1);
    check({tag, "_write"}, o_mem_write, 0);
    check({tag, "_addr"}, o_mem_addr, 0);
    check({tag, "_wdata"}, o_mem_wdata, 0);
    check({tag, "_acks"}, {o_vic_ack, o_cpu_ack, o_aux_ack}, 0);
    check({tag, "_rdata"}, o_rdata, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_owner"}, o_owner, 0);
  endtask

  vec_t vecs [7];
  bit   got;
  int   lat, alat;
  bit   granted [3];
  logic prev_req [3];
  int   prev_owner, cur, pick, ref_starve, acks_seen, aux_idx, vic_before;
  bit   cur_wr;
  logic [7:0] cur_exp;

  initial begin
    for (int k = 0; k < 3; k++) begin
      rq_req[k] = 0; rq_wr[k] = 0; rq_addr[k] = 0; rq_wd[k] = 0; granted[k] = 0; prev_req[k] = 0;
    end
    vecs[0] = '{2, 1'b1, 24'h000001, 8'hAA, 4, 8'h00};
    vecs[1] = '{2, 1'b0, 24'h000001, 8'h00, 4, 8'hAA};
    vecs[2] = '{1, 1'b1, 24'hFFFFFF, 8'h55, 2, 8'hAA};
    vecs[3] = '{0, 1'b0, 24'hFFFFFF, 8'h00, 5, 8'h55};
    vecs[4] = '{1, 1'b0, 24'h123456, 8'h00, 3, 8'h0C};
    vecs[5] = '{0, 1'b1, 24'h800000, 8'h3C, 2, 8'h0C};
    vecs[6] = '{2, 1'b0, 24'h800000, 8'h00, 6, 8'h3C};

    reset = 1;
    repeat (3) step();
    check_reset_outputs("reset");
    reset = 0;
    step();

    // single transactions from the vector table
    for (int v = 0; v < 7; v++) begin
      do_txn(vecs[v].who, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].blen, 200, got, lat, alat);
      check("vec_ack", got, 1);
      if (got) begin
        check("vec_grant_latency", lat, 1);
        check("vec_cs_low_cycles", cs_lows, 1);
        check("vec_owner_at_ack", ack_owner[0], vecs[v].who + 1);
        check("vec_rdata_at_ack", ack_rdata[0], vecs[v].exp_rdata);
        check("vec_mem_addr", o_mem_addr, vecs[v].addr);
        check("vec_mem_write", o_mem_write, vecs[v].wr);
        if (vecs[v].wr) check("vec_mem_wdata", o_mem_wdata, vecs[v].wdata);
      end
      step();
      check("vec_owner_after", o_owner, 0);
      check("vec_ack_pulse_width", {o_vic_ack, o_cpu_ack, o_aux_ack}, 0);
      check("vec_rdata_held", o_rdata, vecs[v].exp_rdata);
    end

    // simultaneous requests
    clear_log();
    busy_len = 3;
    for (int k = 0; k < 3; k++) begin
      rq_wr[k] = 0; rq_addr[k] = 24'h000001; rq_req[k] = 1;
    end
    for (int i = 0; i < 300 && ack_order.size() < 3; i++) step();
    check("simul_ack_count", ack_order.size(), 3);
    for (int i = 0; i < ack_order.size(); i++) begin
      check("simul_order", ack_order[i], i);
      check("simul_owner", ack_owner[i], i + 1);
    end
    repeat (2) step();

    // starvation guard with VIC and CPU always requesting
    clear_log();
    busy_len = 2;
    keep_vc = 1;
    rq_wr[0] = 0; rq_addr[0] = 24'h000001;
    rq_wr[1] = 0; rq_addr[1] = 24'h000001;
    rq_wr[2] = 1; rq_addr[2] = 24'h000100; rq_wd[2] = 8'h77;
    for (int k = 0; k < 3; k++) rq_req[k] = 1;
    for (int i = 0; i < 2000 && !acked[2]; i++) step();
    rq_req[0] = 0; rq_req[1] = 0;
    keep_vc = 0;
    check("starve_aux_acked", acked[2], 1);
    aux_idx = -1; vic_before = 0;
    for (int i = 0; i < ack_order.size(); i++) begin
      if (aux_idx < 0 && ack_order[i] == 2) aux_idx = i;
      if (aux_idx < 0 && ack_order[i] == 0) vic_before++;
    end
    check("starve_aux_slot", aux_idx, 15);
    check("starve_vic_grants_before", vic_before, 15);
    repeat (4) step();
    check("starve_idle_after", o_owner, 0);

    // randomized traffic against the reference model
    clear_log();
    rand_len = 1;
    ref_starve = 0; prev_owner = 0; cur = -1; acks_seen = 0;
    for (int k = 0; k < 3; k++) begin granted[k] = 0; prev_req[k] = 0; end
    for (int c = 0; c < 1500; c++) begin
      step();
      if (ack_order.size() > 0) begin
        check("rnd_ack_who", ack_order[0], cur);
        if (cur >= 0 && !cur_wr) check("rnd_rdata", ack_rdata[0], cur_exp);
        if (cur >= 0) granted[cur] = 0;
        void'(ack_order.pop_front()); void'(ack_owner.pop_front()); void'(ack_rdata.pop_front());
        cur = -1;
        acks_seen++;
      end
      if (!prev_req[2]) ref_starve = 0;
      if (o_owner != 0 && prev_owner == 0) begin
        if (prev_req[2] && ref_starve == 15) pick = 2;
        else if (prev_req[0]) pick = 0;
        else if (prev_req[1]) pick = 1;
        else pick = 2;
        check("rnd_grant_owner", o_owner, pick + 1);
        check("rnd_grant_addr", o_mem_addr, rq_addr[pick]);
        check("rnd_grant_write", o_mem_write, rq_wr[pick]);
        if (rq_wr[pick]) check("rnd_grant_wdata", o_mem_wdata, rq_wd[pick]);
        cur = pick;
        cur_wr = rq_wr[pick];
        if (cur_wr) ref_mem[rq_addr[pick]] = rq_wd[pick];
        else cur_exp = ref_mem.exists(rq_addr[pick]) ? ref_mem[rq_addr[pick]] : dflt(rq_addr[pick]);
        granted[pick] = 1;
        if (pick == 2) ref_starve = 0;
        else if (prev_req[2] && ref_starve < 15) ref_starve++;
      end
      prev_owner = int'(o_owner);
      for (int k = 0; k < 3; k++) begin
        if (c >= 1300) begin
          if (rq_req[k] && !granted[k]) rq_req[k] = 0;
        end else if (!rq_req[k]) begin
          if ($urandom_range(0, (k == 2) ? 5 : 3) == 0) begin
            rq_wr[k] = 1'($urandom_range(0, 1));
            rq_addr[k] = ($urandom_range(0, 1) ? 24'hFFFF00 : 24'h000040) | 24'($urandom_range(0, 7));
            rq_wd[k] = 8'($urandom);
            rq_req[k] = 1;
          end
        end else if (!granted[k] && $urandom_range(0, 15) == 0) begin
          rq_req[k] = 0;
        end
      end
      for (int k = 0; k < 3; k++) prev_req[k] = rq_req[k];
    end
    check("rnd_drained", {rq_req[0], rq_req[1], rq_req[2], o_owner}, 0);
    check("rnd_activity", acks_seen > 40, 1);
    rand_len = 0;
    clear_log();

    // timeout on a read, then sticky error through good transactions
    mem_dead = 1;
    do_txn(1, 0, 24'h000010, 8'h00, 4, TIMEOUT + 100, got, lat, alat);
    check("timeout_read_acked", got, 1);
    check("timeout_latency_in_range", (alat >= TIMEOUT) && (alat <= TIMEOUT + 8), 1);
    check("timeout_err", o_err, 1);
    check("timeout_rdata_ff", o_rdata, 8'hFF);
    mem_dead = 0;
    step();
    do_txn(0, 1, 24'h000030, 8'h5E, 3, 200, got, lat, alat);
    check("post_timeout_write_acked", got, 1);
    do_txn(2, 0, 24'h000030, 8'h00, 3, 200, got, lat, alat);
    check("post_timeout_read_acked", got, 1);
    check("post_timeout_rdata", o_rdata, 8'h5E);
    check("err_sticky", o_err, 1);
    mem_dead = 1;
    do_txn(2, 1, 24'h000020, 8'h99, 4, TIMEOUT + 100, got, lat, alat);
    check("timeout_write_acked", got, 1);
    check("timeout_write_rdata_kept", o_rdata, 8'h5E);
    check("timeout_write_err", o_err, 1);
    mem_dead = 0;
    step();

    // reset while waiting for busy to fall
    clear_log();
    busy_len = 8;
    rq_wr[1] = 0; rq_addr[1] = 24'h000030; rq_req[1] = 1;
    for (int i = 0; i < 20 && cs_lows == 0; i++) step();
    repeat (4) step();
    check("midreset_in_flight", {mem_busy, o_owner}, {1'b1, 2'd2});
    reset = 1;
    step();
    check_reset_outputs("midreset");
    rq_req[1] = 0;
    step();
    reset = 0;
    repeat (5) step();
    check("midreset_no_ack", ack_order.size(), 0);
    do_txn(1, 0, 24'h000030, 8'h00, 3, 200, got, lat, alat);
    check("after_reset_read_acked", got, 1);
    check("after_reset_rdata", o_rdata, 8'h5E);
    check("after_reset_err_clear", o_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psram_arbiter.md
Name: psram_arbiter

Overview:
- Shares the single PSRAM controller (memCtrl) between three requesters: VIC (video fetch), CPU (6502 bus), and AUX (RAM test / loader sequencer).
- Fixed priority VIC > CPU > AUX, with a starvation guard for AUX.
- Sequences each memCtrl transaction: chip-select pulse, busy tracking, read-data capture, completion ack.
- Sits between the requesters and memCtrl in gm64, all on clkSys.

Parameters:
- ADDR_W, 24, PSRAM byte address width.
- DATA_W, 8, data width.
- TIMEOUT, 1023, max clkSys cycles to wait for any memCtrl phase before abort.
- STARVE_LIMIT, 15, consecutive VIC/CPU grants while AUX is pending before AUX is forced next.

Ports:
- clkSys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- i_vic_req / i_cpu_req / i_aux_req  in  1 each  request; held high until the matching ack.
- i_vic_write / i_cpu_write / i_aux_write  in  1 each  1=write, 0=read; sampled at grant.
- i_vic_addr / i_cpu_addr / i_aux_addr  in  ADDR_W each  address; sampled at grant.
- i_vic_wdata / i_cpu_wdata / i_aux_wdata  in  DATA_W each  write data; sampled at grant.
- o_vic_ack / o_cpu_ack / o_aux_ack  out  1 each  one-cycle completion pulse.
- o_rdata  out  DATA_W  read data; valid in the ack cycle, held until the next read completes.
- o_err  out  1  sticky timeout flag; cleared only by reset.
- o_mem_cs_n  out  1  to memCtrl i_cs, active low.
- o_mem_write  out  1  to memCtrl i_write.
- o_mem_addr  out  ADDR_W  to memCtrl i_address.
- o_mem_wdata  out  DATA_W  to memCtrl i_dataToWrite.
- i_mem_rdata  in  DATA_W  from memCtrl o_dataRead.
- i_mem_busy  in  1  from memCtrl o_busy.
- i_mem_ready  in  1  from memCtrl o_dataReady.
- o_owner  out  2  current owner: 0 none, 1 VIC, 2 CPU, 3 AUX (debug colour source).

Behaviour:
- Reset (synchronous, active-high, on clkSys edge):
  - outputs: o_mem_cs_n=1, o_mem_write=0, o_mem_addr=0, o_mem_wdata=0, all acks 0, o_rdata=0, o_err=0, o_owner=0.
  - state IDLE, starvation counter 0.
  - Asserting reset mid-transaction aborts it: no ack is issued and cs_n returns to 1 the next cycle.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ACK.
- IDLE:
  - If i_mem_busy=1, stay in IDLE.
  - Otherwise select a winner among pending reqs:
    - AUX if it is pending and starve counter = STARVE_LIMIT;
    - else VIC, then CPU, then AUX.
  - Latch write/addr/wdata into o_mem_*, set o_owner, go to ISSUE.
  - Idle to cs_n low = 1 cycle.
- ISSUE:
  - o_mem_cs_n=0 for exactly one cycle.
  - Clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - cs_n=1; wait for i_mem_busy=1, then go to WAIT_DONE.
- WAIT_DONE:
  - Wait for i_mem_busy=0.
  - Write: busy low completes the transaction.
  - Read: completion additionally requires i_mem_ready=1 in the same cycle as busy=0; capture i_mem_rdata into o_rdata that cycle.
  - Go to ACK.
- ACK:
  - Pulse the owner's ack for one cycle; o_owner returns to 0; go to IDLE.
  - A req still high in the cycle after ack is treated as a new request.
  - Minimum gap between grants is one IDLE cycle.
- Timeout:
  - In WAIT_BUSY or WAIT_DONE, the counter increments each cycle; when it equals TIMEOUT:
    - set o_err;
    - o_rdata=8'hFF for a read (unchanged for a write);
    - go to ACK (the requester is still acked, so nothing hangs).
  - The counter saturates; no wrap.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each VIC/CPU grant made while AUX req=1.
  - Resets to 0 on an AUX grant or when AUX req=0.
- Simultaneous requests are resolved only in IDLE; requests arriving mid-transaction wait.
- A request withdrawn before grant is ignored.
- Address is passed through unchanged; no wrap logic (full 24 bit).

Decomposition:
- Shared package gm64_pkg:
  - typedef enum for arbiter state;
  - typedef enum bit[1:0] owner {none, vic, cpu, aux};
  - parameters ADDR_W/DATA_W;
  - Color enum moved there.
- One sub-module, psram_prio_select: combinational winner pick from reqs + starve flag → owner.

Test Plan:
1. Reset, AUX writes 8'hAA @24'h000001, memCtrl model busy 4 cycles → cs_n low exactly 1 cycle, o_aux_ack 1 pulse, o_mem_addr=24'h000001, o_mem_wdata=8'hAA.
2. AUX read @24'h000001, model returns 8'hAA with ready at busy fall → o_rdata=8'hAA in o_aux_ack cycle, held after.
3. VIC, CPU, AUX req in same cycle → grant order VIC, CPU, AUX; o_owner sequence 1,2,3; three acks, never overlapping.
4. VIC+CPU continuously requesting, AUX pending → AUX granted after the 15th VIC/CPU grant (16th slot).
5. Model never raises busy → ack after TIMEOUT cycles, o_err=1, o_rdata=8'hFF for a read; o_err stays 1 through later good transactions until reset.
6. Reset asserted in WAIT_DONE → no ack, next-cycle outputs at reset values; after release, a new CPU read completes normally.
